pc_sequencer: RTL and testbench

- Registered program-counter sequencer for the single-cycle MIPS core.
- Consumes next-address results (sequential PC+1, branch, jump) and presents one instruction address per cycle to instruction memory over a valid/ready handshake.
- Owns the PC register, start-up bubble and halt control, so the datapath adders stay purely combinational.

---
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-side bus between the PC sequencer (master) and instruction memory /
// next-address datapath (slave): fetch handshake plus redirect controls.
interface pc_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              pc_ready;
    logic              branch_en;
    logic [ADDR_W-1:0] branch_off;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_target;
    logic              call_en;
    logic              ret_en;
    logic              halt_req;
    logic              resume;

    // Handshake: a fetch transfers on any rising edge where pc_valid && pc_ready.
    // pc/pc_valid are held stable until that transfer; redirects are sampled only then.
    modport master (
        output pc, pc_valid,
        input  pc_ready, branch_en, branch_off, jump_en, jump_target,
               call_en, ret_en, halt_req, resume
    );

    modport slave (
        input  pc, pc_valid,
        output pc_ready, branch_en, branch_off, jump_en, jump_target,
               call_en, ret_en, halt_req, resume
    );
endinterface

// File: rtl/pc_sequencer.sv
// Registered PC sequencer: IDLE/RUN/HALT FSM, next-PC selection on fetch handshake.
// Optional return-address stack built when macro PC_RAS_EN is defined.
module pc_sequencer #(
    parameter int                ADDR_W    = 5,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pc_sequencer_if.master      bus,
    output logic [1:0]          state,
    output logic                ras_err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_pc_valid;

    logic              w_fire;
    logic [ADDR_W-1:0] w_seq_pc;
    logic [ADDR_W-1:0] w_br_pc;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_ret_take;
    logic [ADDR_W-1:0] w_ret_pc;

    assign w_fire   = r_pc_valid & bus.pc_ready;
    assign w_seq_pc = r_pc + ADDR_W'(1);
    assign w_br_pc  = w_seq_pc + bus.branch_off;

`ifdef PC_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]     r_wp;
    logic [CW-1:0]     r_cnt;
    logic              r_ras_err;

    logic [PW-1:0]     w_wp_inc;
    logic [PW-1:0]     w_wp_dec;
    logic              w_ras_empty;
    logic              w_ras_full;
    logic              w_push;
    logic              w_pop;

    // Circular buffer: pushing when full overwrites the oldest entry naturally.
    assign w_wp_inc    = (r_wp == PW'(RAS_DEPTH - 1)) ? '0 : r_wp + PW'(1);
    assign w_wp_dec    = (r_wp == '0) ? PW'(RAS_DEPTH - 1) : r_wp - PW'(1);
    assign w_ras_empty = (r_cnt == '0);
    assign w_ras_full  = (r_cnt == CW'(RAS_DEPTH));
    assign w_pop       = w_fire & bus.ret_en;
    assign w_push      = w_fire & ~bus.ret_en & bus.call_en;
    assign w_ret_take  = bus.ret_en;
    assign w_ret_pc    = w_ras_empty ? w_seq_pc : r_ras[w_wp_dec];
    assign ras_err     = r_ras_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
            r_wp      <= '0;
            r_cnt     <= '0;
            r_ras_err <= 1'b0;
        end else if (w_pop) begin
            if (w_ras_empty) begin
                r_ras_err <= 1'b1;
            end else begin
                r_wp  <= w_wp_dec;
                r_cnt <= r_cnt - CW'(1);
            end
        end else if (w_push) begin
            r_ras[r_wp] <= w_seq_pc;
            r_wp        <= w_wp_inc;
            if (w_ras_full) r_ras_err <= 1'b1;
            else            r_cnt     <= r_cnt + CW'(1);
        end
    end
`else
    logic w_unused;

    assign w_ret_take = 1'b0;
    assign w_ret_pc   = w_seq_pc;
    assign ras_err    = 1'b0;
    assign w_unused   = &{1'b0, bus.ret_en, RAS_DEPTH[0]};
`endif

    // Priority: return > call/jump > branch > sequential.
    always_comb begin
        w_next_pc = w_seq_pc;
        if (w_ret_take)                      w_next_pc = w_ret_pc;
        else if (bus.call_en || bus.jump_en) w_next_pc = bus.jump_target;
        else if (bus.branch_en)              w_next_pc = w_br_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state    <= RUN;
                    r_pc_valid <= 1'b1;
                end
                RUN: begin
                    if (w_fire) r_pc <= w_next_pc;
                    if (bus.halt_req) begin
                        r_state    <= HALT;
                        r_pc_valid <= 1'b0;
                    end
                end
                HALT: begin
                    if (bus.resume && !bus.halt_req) begin
                        r_state    <= RUN;
                        r_pc_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_pc_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc       = r_pc;
    assign bus.pc_valid = r_pc_valid;
    assign state        = r_state;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; RAS scenarios run when PC_RAS_EN is defined.
module tb_pc_sequencer;
    localparam int ADDR_W = 5;

    logic       clk;
    logic       rst_n;
    logic [1:0] state;
    logic       ras_err;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    pc_sequencer #(.ADDR_W(ADDR_W), .RESET_PC('0), .RAS_DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.master),
        .state   (state),
        .ras_err (ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.pc_ready    = 1'b1;
        bus.branch_en   = 1'b0;
        bus.branch_off  = '0;
        bus.jump_en     = 1'b0;
        bus.jump_target = '0;
        bus.call_en     = 1'b0;
        bus.ret_en      = 1'b0;
        bus.halt_req    = 1'b0;
        bus.resume      = 1'b0;
    endtask

    task automatic jump_to(input logic [ADDR_W-1:0] t);
        bus.jump_en     = 1'b1;
        bus.jump_target = t;
        step();
        bus.jump_en     = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        n_checks++; if (bus.pc !== 5'd0) begin n_fail++; $display("FAIL rst_pc got=%0d exp=0", bus.pc); end
        n_checks++; if (bus.pc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0b exp=0", bus.pc_valid); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state got=%0d exp=0", state); end
        n_checks++; if (ras_err !== 1'b0) begin n_fail++; $display("FAIL rst_ras_err got=%0b exp=0", ras_err); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.pc_valid !== 1'b0) begin n_fail++; $display("FAIL start_bubble got=%0b exp=0", bus.pc_valid); end
        step();
        n_checks++; if (bus.pc_valid !== 1'b1 || bus.pc !== 5'd0 || state !== 2'd1) begin
            n_fail++; $display("FAIL start_first valid=%0b pc=%0d state=%0d exp 1/0/1", bus.pc_valid, bus.pc, state);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++; if (bus.pc !== 5'(i)) begin n_fail++; $display("FAIL start_seq got=%0d exp=%0d", bus.pc, i); end
        end
    endtask

    task automatic test_backpressure();
        step();
        step();
        n_checks++; if (bus.pc !== 5'd5) begin n_fail++; $display("FAIL bp_setup got=%0d exp=5", bus.pc); end
        bus.pc_ready   = 1'b0;
        bus.branch_off = 5'd3;
        for (int i = 0; i < 3; i++) begin
            bus.branch_en = (i % 2 == 0);
            step();
            n_checks++; if (bus.pc !== 5'd5 || bus.pc_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold pc=%0d valid=%0b exp 5/1", bus.pc, bus.pc_valid);
            end
        end
        bus.branch_en = 1'b0;
        bus.pc_ready  = 1'b1;
        step();
        n_checks++; if (bus.pc !== 5'd6) begin n_fail++; $display("FAIL bp_release got=%0d exp=6", bus.pc); end
    endtask

    task automatic test_wrap_priority();
        jump_to(5'd31);
        n_checks++; if (bus.pc !== 5'd31) begin n_fail++; $display("FAIL jump31 got=%0d exp=31", bus.pc); end
        step();
        n_checks++; if (bus.pc !== 5'd0) begin n_fail++; $display("FAIL wrap got=%0d exp=0", bus.pc); end
        jump_to(5'd2);
        bus.branch_en   = 1'b1;
        bus.branch_off  = 5'b11100;
        bus.jump_en     = 1'b1;
        bus.jump_target = 5'd9;
        step();
        n_checks++; if (bus.pc !== 5'd9) begin n_fail++; $display("FAIL prio_jump got=%0d exp=9", bus.pc); end
        bus.branch_en = 1'b0;
        jump_to(5'd2);
        bus.branch_en = 1'b1;
        step();
        bus.branch_en = 1'b0;
        n_checks++; if (bus.pc !== 5'd31) begin n_fail++; $display("FAIL branch_neg got=%0d exp=31", bus.pc); end
    endtask

    task automatic test_halt();
        jump_to(5'd7);
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        n_checks++; if (bus.pc !== 5'd8 || state !== 2'd2 || bus.pc_valid !== 1'b0) begin
            n_fail++; $display("FAIL halt_enter pc=%0d state=%0d valid=%0b exp 8/2/0", bus.pc, state, bus.pc_valid);
        end
        bus.jump_en     = 1'b1;
        bus.jump_target = 5'd20;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (bus.pc !== 5'd8 || state !== 2'd2) begin
                n_fail++; $display("FAIL halt_hold pc=%0d state=%0d exp 8/2", bus.pc, state);
            end
        end
        bus.jump_en  = 1'b0;
        bus.halt_req = 1'b1;
        bus.resume   = 1'b1;
        step();
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL halt_both got=%0d exp=2", state); end
        bus.halt_req = 1'b0;
        step();
        bus.resume = 1'b0;
        n_checks++; if (state !== 2'd1 || bus.pc_valid !== 1'b1 || bus.pc !== 5'd8) begin
            n_fail++; $display("FAIL resume state=%0d valid=%0b pc=%0d exp 1/1/8", state, bus.pc_valid, bus.pc);
        end
        step();
        n_checks++; if (bus.pc !== 5'd9) begin n_fail++; $display("FAIL resume_seq got=%0d exp=9", bus.pc); end
    endtask

`ifdef PC_RAS_EN
    task automatic test_ras_calls();
        jump_to(5'd3);
        bus.call_en     = 1'b1;
        bus.jump_target = 5'd20;
        step();
        bus.call_en = 1'b0;
        n_checks++; if (bus.pc !== 5'd20) begin n_fail++; $display("FAIL call got=%0d exp=20", bus.pc); end
        bus.ret_en = 1'b1;
        step();
        bus.ret_en = 1'b0;
        n_checks++; if (bus.pc !== 5'd4) begin n_fail++; $display("FAIL ret got=%0d exp=4", bus.pc); end
        for (int i = 0; i < 4; i++) begin
            bus.call_en     = 1'b1;
            bus.jump_target = 5'(10 + i);
            step();
        end
        n_checks++; if (ras_err !== 1'b0 || bus.pc !== 5'd13) begin
            n_fail++; $display("FAIL ras_full err=%0b pc=%0d exp 0/13", ras_err, bus.pc);
        end
        bus.jump_target = 5'd14;
        step();
        bus.call_en = 1'b0;
        n_checks++; if (ras_err !== 1'b1 || bus.pc !== 5'd14) begin
            n_fail++; $display("FAIL ras_overflow err=%0b pc=%0d exp 1/14", ras_err, bus.pc);
        end
        for (int i = 0; i < 4; i++) begin
            bus.ret_en = 1'b1;
            step();
            n_checks++; if (bus.pc !== 5'(14 - i)) begin
                n_fail++; $display("FAIL ras_pop got=%0d exp=%0d", bus.pc, 14 - i);
            end
        end
        bus.ret_en = 1'b0;
    endtask
`endif

    task automatic test_async_reset();
        jump_to(5'd12);
        n_checks++; if (bus.pc !== 5'd12) begin n_fail++; $display("FAIL ar_setup got=%0d exp=12", bus.pc); end
        bus.jump_en     = 1'b1;
        bus.jump_target = 5'd25;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.pc !== 5'd0 || bus.pc_valid !== 1'b0 || state !== 2'd0 || ras_err !== 1'b0) begin
            n_fail++; $display("FAIL async_rst pc=%0d valid=%0b state=%0d err=%0b exp 0/0/0/0",
                               bus.pc, bus.pc_valid, state, ras_err);
        end
        #1;
        rst_n = 1'b1;
        step();
        bus.jump_en = 1'b0;
        n_checks++; if (bus.pc !== 5'd0 || bus.pc_valid !== 1'b1) begin
            n_fail++; $display("FAIL ar_restart pc=%0d valid=%0b exp 0/1", bus.pc, bus.pc_valid);
        end
    endtask

    task automatic test_ret_empty();
        logic exp_err;
`ifdef PC_RAS_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        jump_to(5'd10);
        n_checks++; if (ras_err !== 1'b0) begin n_fail++; $display("FAIL ret_empty_pre got=%0b exp=0", ras_err); end
        bus.ret_en = 1'b1;
        step();
        bus.ret_en = 1'b0;
        n_checks++; if (bus.pc !== 5'd11) begin n_fail++; $display("FAIL ret_empty_pc got=%0d exp=11", bus.pc); end
        n_checks++; if (ras_err !== exp_err) begin n_fail++; $display("FAIL ret_empty_err got=%0b exp=%0b", ras_err, exp_err); end
        step();
        n_checks++; if (ras_err !== exp_err || bus.pc !== 5'd12) begin
            n_fail++; $display("FAIL ret_empty_sticky err=%0b pc=%0d exp %0b/12", ras_err, bus.pc, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_wrap_priority();
        test_halt();
`ifdef PC_RAS_EN
        test_ras_calls();
`endif
        test_async_reset();
        test_ret_empty();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
